serial_nibble_receiver: RTL and testbench
=========================================

SERIAL_NIBBLE_RECEIVER -- requirements
Module: serial_nibble_receiver

Interface
REQ-001 Parameter MSB_FIRST, default 0: 0 means data bits arrive LSB first; 1 means data bits arrive MSB first.
REQ-002 clock  input  1  Single clock; all state changes on the rising edge.
REQ-003 resetn  input  1  Reset, asynchronous and active-low.
REQ-004 serial_in  input  1  Serial line; idle high; sampled only when bit_en=1.
REQ-005 bit_en  input  1  Bit strobe; one bit is consumed per rising edge with bit_en=1.
REQ-006 out_ready  input  1  Downstream ready for a nibble.
REQ-007 nibble  output  4  Received data; held stable while nibble_valid=1.
REQ-008 nibble_valid  output  1  nibble holds an unconsumed word.
REQ-009 frame_err  output  1  One-cycle pulse on a bad stop bit or bad parity bit.
REQ-010 overrun  output  1  One-cycle pulse when a good frame is dropped.
REQ-011 busy  output  1  High in every state except IDLE.

Function
REQ-012 FSM states SHALL be IDLE, DATA, PARITY, STOP; every transition occurs only on an edge where bit_en=1, and state holds when bit_en=0.
REQ-013 IDLE: serial_in=0 SHALL move to DATA with bit counter=0; serial_in=1 SHALL stay in IDLE.
REQ-014 DATA: each sample SHALL be written to shift register bit counter (MSB_FIRST=0) or bit 3-counter (MSB_FIRST=1); the 2-bit counter increments; after the 4th bit, go to PARITY if enabled, else STOP.
REQ-015 PARITY: the sampled bit SHALL be compared with even parity (XOR of the 4 data bits); a mismatch is latched as an error; go to STOP.
REQ-016 STOP: always return to IDLE; serial_in=1 with no latched error means the frame is good; otherwise frame_err pulses high for exactly the next cycle and the data is discarded.
REQ-017 For a good frame with nibble_valid=0, or with nibble_valid=1 and out_ready=1 on the same edge, nibble and nibble_valid=1 SHALL update on the STOP-sampling edge (zero added latency).
REQ-018 A transfer SHALL occur on any edge with nibble_valid=1 and out_ready=1; nibble_valid clears unless REQ-017 reloads it on the same edge.
REQ-019 For a good frame with nibble_valid=1 and out_ready=0: nibble is unchanged, the new data is dropped, and overrun pulses for one cycle.
REQ-020 A back-to-back start bit on the bit_en immediately after STOP SHALL be accepted (no idle bit required).
REQ-021 frame_err and overrun SHALL never be high simultaneously.

Reset
REQ-022 resetn=0 SHALL immediately force IDLE, counter=0, shift register=0, nibble=0, nibble_valid=0, frame_err=0, overrun=0, busy=0, including in the middle of a frame.
REQ-023 After resetn deasserts, the first frame SHALL be received correctly with no dummy edges needed.

Configuration
REQ-024 Macro SNR_PARITY_EN defined: the PARITY state exists and a frame is start+4 data+parity+stop (7 bits).
REQ-025 Macro SNR_PARITY_EN undefined: no PARITY state or logic; a frame is start+4 data+stop (6 bits); frame_err arises from the stop bit only.

Verification
REQ-026 PARITY_EN on, MSB_FIRST=0, out_ready=1, bits 0,0,1,0,1,0,1 on consecutive bit_en -> nibble=4'hA, nibble_valid high 1 cycle, frame_err=0.
REQ-027 Same as REQ-026 with parity bit 1 -> frame_err pulse, nibble_valid stays 0, nibble unchanged.
REQ-028 out_ready=0, two good frames 4'h3 then 4'h5 -> nibble=4'h3 held, overrun pulse at the end of the second frame; out_ready=1 then clears valid.
REQ-029 resetn pulsed low after the 2nd data bit, then a full frame 4'hC -> busy=0 during reset, then nibble=4'hC with no error.
REQ-030 bit_en only 1 cycle in 3, stop bit 0 -> state holds between strobes, frame_err pulse, IDLE afterwards; PARITY_EN off and MSB_FIRST=1, bits 0,1,0,0,1,1 -> nibble=4'h9.

Source files
------------

// File: rtl/serial_nibble_receiver.sv
// Serial nibble receiver: start bit, 4 data bits, optional even parity, stop bit, one bit per bit_en strobe.
// Compile-time option: define SNR_PARITY_EN to add the parity bit to each frame.
module serial_nibble_receiver #(
    parameter bit MSB_FIRST = 1'b0
) (
    input  logic       clock,
    input  logic       resetn,
    input  logic       serial_in,
    input  logic       bit_en,
    input  logic       out_ready,
    output logic [3:0] nibble,
    output logic       nibble_valid,
    output logic       frame_err,
    output logic       overrun,
    output logic       busy
);

    // state  | meaning
    // IDLE   | line idle, waiting for a low start bit
    // DATA   | sampling the four data bits
    // PARITY | sampling the even-parity bit (SNR_PARITY_EN builds only)
    // STOP   | sampling the stop bit, then delivering or dropping the nibble
`ifdef SNR_PARITY_EN
    typedef enum logic [1:0] {IDLE = 2'd0, DATA = 2'd1, STOP = 2'd2, PARITY = 2'd3} state_t;
`else
    typedef enum logic [1:0] {IDLE = 2'd0, DATA = 2'd1, STOP = 2'd2} state_t;
`endif

    state_t     state;
    logic [1:0] bit_cnt;
    logic [1:0] bit_idx;
    logic [3:0] shift_reg;
    logic       stop_good;
`ifdef SNR_PARITY_EN
    logic       parity_err;
`endif

    always_comb begin
        bit_idx = MSB_FIRST ? ~bit_cnt : bit_cnt;
`ifdef SNR_PARITY_EN
        stop_good = serial_in && !parity_err;
`else
        stop_good = serial_in;
`endif
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state        <= IDLE;
            bit_cnt      <= 2'd0;
            shift_reg    <= 4'd0;
            nibble       <= 4'd0;
            nibble_valid <= 1'b0;
            frame_err    <= 1'b0;
            overrun      <= 1'b0;
            busy         <= 1'b0;
`ifdef SNR_PARITY_EN
            parity_err   <= 1'b0;
`endif
        end else begin
            frame_err <= 1'b0;
            overrun   <= 1'b0;
            // A transfer clears valid; a good frame on the same edge reloads it below.
            if (nibble_valid && out_ready)
                nibble_valid <= 1'b0;
            if (bit_en) begin
                case (state)
                    IDLE: begin
                        if (!serial_in) begin
                            state   <= DATA;
                            bit_cnt <= 2'd0;
                            busy    <= 1'b1;
`ifdef SNR_PARITY_EN
                            parity_err <= 1'b0;
`endif
                        end
                    end
                    DATA: begin
                        shift_reg[bit_idx] <= serial_in;
                        bit_cnt            <= bit_cnt + 2'd1;
                        if (bit_cnt == 2'd3) begin
`ifdef SNR_PARITY_EN
                            state <= PARITY;
`else
                            state <= STOP;
`endif
                        end
                    end
`ifdef SNR_PARITY_EN
                    PARITY: begin
                        if (serial_in != (^shift_reg))
                            parity_err <= 1'b1;
                        state <= STOP;
                    end
`endif
                    STOP: begin
                        state <= IDLE;
                        busy  <= 1'b0;
                        if (stop_good) begin
                            if (!nibble_valid || out_ready) begin
                                nibble       <= shift_reg;
                                nibble_valid <= 1'b1;
                            end else begin
                                overrun <= 1'b1;
                            end
                        end else begin
                            frame_err <= 1'b1;
                        end
                    end
                    default: begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_serial_nibble_receiver.sv
// Directed bench for serial_nibble_receiver: LSB-first and MSB-first instances share one stimulus stream.
module tb_serial_nibble_receiver;

    logic clock = 1'b0;
    logic resetn = 1'b0;
    logic serial_in = 1'b1;
    logic bit_en = 1'b0;
    logic out_ready = 1'b0;

    logic [3:0] n_l, n_m;
    logic v_l, fe_l, ov_l, b_l;
    logic v_m, fe_m, ov_m, b_m;

    int checks = 0;
    int failures = 0;

    always #5 clock = ~clock;

    serial_nibble_receiver #(.MSB_FIRST(1'b0)) u_lsb (
        .clock(clock), .resetn(resetn), .serial_in(serial_in), .bit_en(bit_en),
        .out_ready(out_ready), .nibble(n_l), .nibble_valid(v_l),
        .frame_err(fe_l), .overrun(ov_l), .busy(b_l));

    serial_nibble_receiver #(.MSB_FIRST(1'b1)) u_msb (
        .clock(clock), .resetn(resetn), .serial_in(serial_in), .bit_en(bit_en),
        .out_ready(out_ready), .nibble(n_m), .nibble_valid(v_m),
        .frame_err(fe_m), .overrun(ov_m), .busy(b_m));

    // One strobed bit; gap idle cycles first with the line driven to the opposite value.
    task automatic send_bit(input logic b, input int gap);
        for (int i = 0; i < gap; i++) begin
            @(negedge clock);
            serial_in = ~b;
            bit_en = 1'b0;
        end
        @(negedge clock);
        serial_in = b;
        bit_en = 1'b1;
        @(posedge clock);
        #1;
        bit_en = 1'b0;
        serial_in = 1'b1;
    endtask

    // v[0] goes on the line first; returns one step after the stop-sampling edge.
    task automatic send_frame(input logic [3:0] v, input logic par_flip, input logic stop_bit);
        send_bit(1'b0, 0);
        for (int i = 0; i < 4; i++) send_bit(v[i], 0);
`ifdef SNR_PARITY_EN
        send_bit((^v) ^ par_flip, 0);
`endif
        send_bit(stop_bit, 0);
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        resetn = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        checks++; if (n_l !== 4'h0) begin failures++; $display("FAIL reset_nibble got=%h exp=0", n_l); end
        checks++; if (v_l !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", v_l); end
        checks++; if (fe_l !== 1'b0) begin failures++; $display("FAIL reset_ferr got=%b exp=0", fe_l); end
        checks++; if (ov_l !== 1'b0) begin failures++; $display("FAIL reset_overrun got=%b exp=0", ov_l); end
        checks++; if (b_l !== 1'b0 || b_m !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b%b exp=00", b_l, b_m); end
        @(negedge clock);
        resetn = 1'b1;
    endtask

    task automatic test_good_frame();
        out_ready = 1'b1;
        send_bit(1'b0, 0);
        checks++; if (b_l !== 1'b1) begin failures++; $display("FAIL busy_after_start got=%b exp=1", b_l); end
        for (int i = 0; i < 4; i++) send_bit(i[0], 0);  // line 0,1,0,1 -> 4'hA LSB first
`ifdef SNR_PARITY_EN
        send_bit(1'b0, 0);
`endif
        send_bit(1'b1, 0);
        checks++; if (n_l !== 4'hA) begin failures++; $display("FAIL good_nibble got=%h exp=a", n_l); end
        checks++; if (v_l !== 1'b1) begin failures++; $display("FAIL good_valid got=%b exp=1", v_l); end
        checks++; if (fe_l !== 1'b0 || ov_l !== 1'b0) begin failures++; $display("FAIL good_flags got=%b%b exp=00", fe_l, ov_l); end
        checks++; if (b_l !== 1'b0) begin failures++; $display("FAIL good_busy got=%b exp=0", b_l); end
        tick();
        checks++; if (v_l !== 1'b0) begin failures++; $display("FAIL good_valid_oneshot got=%b exp=0", v_l); end
    endtask

    task automatic test_frame_error();
        out_ready = 1'b1;
`ifdef SNR_PARITY_EN
        send_frame(4'b0101, 1'b1, 1'b1);
`else
        send_frame(4'b0101, 1'b0, 1'b0);
`endif
        checks++; if (fe_l !== 1'b1) begin failures++; $display("FAIL err_pulse got=%b exp=1", fe_l); end
        checks++; if (v_l !== 1'b0) begin failures++; $display("FAIL err_valid got=%b exp=0", v_l); end
        checks++; if (ov_l !== 1'b0) begin failures++; $display("FAIL err_overrun got=%b exp=0", ov_l); end
        tick();
        checks++; if (fe_l !== 1'b0) begin failures++; $display("FAIL err_pulse_width got=%b exp=0", fe_l); end
        // Distinct data with an error must not disturb the held nibble.
`ifdef SNR_PARITY_EN
        send_frame(4'b0110, 1'b1, 1'b1);
`else
        send_frame(4'b0110, 1'b0, 1'b0);
`endif
        checks++; if (n_l !== 4'hA) begin failures++; $display("FAIL err_nibble_kept got=%h exp=a", n_l); end
    endtask

    task automatic test_overrun();
        out_ready = 1'b0;
        send_frame(4'h3, 1'b0, 1'b1);
        checks++; if (n_l !== 4'h3 || v_l !== 1'b1) begin failures++; $display("FAIL ovr_first got=%h/%b exp=3/1", n_l, v_l); end
        checks++; if (ov_l !== 1'b0) begin failures++; $display("FAIL ovr_first_flag got=%b exp=0", ov_l); end
        send_frame(4'h5, 1'b0, 1'b1);
        checks++; if (n_l !== 4'h3) begin failures++; $display("FAIL ovr_held got=%h exp=3", n_l); end
        checks++; if (ov_l !== 1'b1 || fe_l !== 1'b0) begin failures++; $display("FAIL ovr_pulse got=%b/%b exp=1/0", ov_l, fe_l); end
        tick();
        checks++; if (ov_l !== 1'b0 || v_l !== 1'b1) begin failures++; $display("FAIL ovr_after got=%b/%b exp=0/1", ov_l, v_l); end
        @(negedge clock);
        out_ready = 1'b1;
        tick();
        checks++; if (v_l !== 1'b0) begin failures++; $display("FAIL ovr_drain got=%b exp=0", v_l); end
    endtask

    task automatic test_reset_mid_frame();
        out_ready = 1'b0;
        send_frame(4'h7, 1'b0, 1'b1);
        send_bit(1'b0, 0);
        send_bit(1'b1, 0);
        send_bit(1'b1, 0);
        checks++; if (b_l !== 1'b1 || v_l !== 1'b1) begin failures++; $display("FAIL mid_before got=%b/%b exp=1/1", b_l, v_l); end
        #3 resetn = 1'b0;
        #1;
        checks++; if (b_l !== 1'b0) begin failures++; $display("FAIL mid_reset_busy got=%b exp=0", b_l); end
        checks++; if (v_l !== 1'b0 || n_l !== 4'h0) begin failures++; $display("FAIL mid_reset_out got=%b/%h exp=0/0", v_l, n_l); end
        repeat (2) @(posedge clock);
        @(negedge clock);
        resetn = 1'b1;
        out_ready = 1'b1;
        send_frame(4'hC, 1'b0, 1'b1);
        checks++; if (n_l !== 4'hC || v_l !== 1'b1) begin failures++; $display("FAIL mid_after got=%h/%b exp=c/1", n_l, v_l); end
        checks++; if (fe_l !== 1'b0) begin failures++; $display("FAIL mid_after_err got=%b exp=0", fe_l); end
        tick();
    endtask

    task automatic test_strobe_gaps();
        out_ready = 1'b1;
        send_bit(1'b0, 0);
        repeat (2) tick();
        checks++; if (b_l !== 1'b1) begin failures++; $display("FAIL gap_busy got=%b exp=1", b_l); end
        send_bit(1'b0, 0);
        send_bit(1'b1, 2);
        send_bit(1'b1, 2);
        send_bit(1'b0, 2);
`ifdef SNR_PARITY_EN
        send_bit(1'b0, 2);
`endif
        send_bit(1'b0, 2);
        checks++; if (fe_l !== 1'b1) begin failures++; $display("FAIL gap_err got=%b exp=1", fe_l); end
        checks++; if (b_l !== 1'b0 || v_l !== 1'b0) begin failures++; $display("FAIL gap_idle got=%b/%b exp=0/0", b_l, v_l); end
        tick();
        checks++; if (fe_l !== 1'b0) begin failures++; $display("FAIL gap_err_width got=%b exp=0", fe_l); end
    endtask

    task automatic test_msb_first();
        out_ready = 1'b1;
        send_frame(4'b1001, 1'b0, 1'b1);
        checks++; if (n_m !== 4'h9 || v_m !== 1'b1) begin failures++; $display("FAIL msb_9 got=%h/%b exp=9/1", n_m, v_m); end
        send_frame(4'b0011, 1'b0, 1'b1);  // line 1,1,0,0
        checks++; if (n_m !== 4'hC) begin failures++; $display("FAIL msb_c got=%h exp=c", n_m); end
        checks++; if (n_l !== 4'h3) begin failures++; $display("FAIL lsb_3 got=%h exp=3", n_l); end
        tick();
    endtask

    task automatic test_back_to_back();
        out_ready = 1'b1;
        send_frame(4'h6, 1'b0, 1'b1);
        checks++; if (n_l !== 4'h6 || v_l !== 1'b1) begin failures++; $display("FAIL b2b_first got=%h/%b exp=6/1", n_l, v_l); end
        send_bit(1'b0, 0);
        checks++; if (b_l !== 1'b1 || v_l !== 1'b0) begin failures++; $display("FAIL b2b_start got=%b/%b exp=1/0", b_l, v_l); end
        for (int i = 0; i < 4; i++) send_bit(i == 0 || i == 3, 0);
`ifdef SNR_PARITY_EN
        send_bit(1'b0, 0);
`endif
        send_bit(1'b1, 0);
        checks++; if (n_l !== 4'h9 || v_l !== 1'b1) begin failures++; $display("FAIL b2b_second got=%h/%b exp=9/1", n_l, v_l); end
        checks++; if (fe_l !== 1'b0 || ov_l !== 1'b0) begin failures++; $display("FAIL b2b_flags got=%b%b exp=00", fe_l, ov_l); end
        tick();
    endtask

    initial begin
        #200000;
        failures++;
        $display("FAIL watchdog timeout reached");
        $fatal(1, "TB_RESULT checks=%0d failures=%0d", checks, failures);
    end

    initial begin
        test_reset();
        test_good_frame();
        test_frame_error();
        test_overrun();
        test_reset_mid_frame();
        test_strobe_gaps();
        test_msb_first();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
